// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: resolves forwarding/immediate select and
// holds results in a two-entry skid buffer so downstream stalls never reach decode combinationally.
module alu_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [OP_WIDTH-1:0]   i_op,
  input  logic [ADDR_WIDTH-1:0] i_rs1Addr,
  input  logic [ADDR_WIDTH-1:0] i_rs2Addr,
  input  logic [DATA_WIDTH-1:0] i_rs1Data,
  input  logic [DATA_WIDTH-1:0] i_rs2Data,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic                  i_useImm,
  input  logic [ADDR_WIDTH-1:0] i_rdAddr,
  input  logic                  i_fwdExValid,
  input  logic [ADDR_WIDTH-1:0] i_fwdExAddr,
  input  logic [DATA_WIDTH-1:0] i_fwdExData,
  input  logic                  i_fwdWbValid,
  input  logic [ADDR_WIDTH-1:0] i_fwdWbAddr,
  input  logic [DATA_WIDTH-1:0] i_fwdWbData,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OP_WIDTH-1:0]   o_op,
  output logic [DATA_WIDTH-1:0] o_dataA,
  output logic [DATA_WIDTH-1:0] o_dataB,
  output logic [ADDR_WIDTH-1:0] o_rdAddr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // EX/MEM result beats MEM/WB; x0 always reads the register file value.
  function automatic logic [DATA_WIDTH-1:0] resolve_src(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  ex_valid,
    input logic [ADDR_WIDTH-1:0] ex_addr,
    input logic [DATA_WIDTH-1:0] ex_data,
    input logic                  wb_valid,
    input logic [ADDR_WIDTH-1:0] wb_addr,
    input logic [DATA_WIDTH-1:0] wb_data
  );
    logic [DATA_WIDTH-1:0] res;
    if (addr == '0) begin
      res = rf_data;
    end else if (ex_valid && (ex_addr == addr)) begin
      res = ex_data;
    end else if (wb_valid && (wb_addr == addr)) begin
      res = wb_data;
    end else begin
      res = rf_data;
    end
    return res;
  endfunction

  state_e                  state_q, state_d, state_fsm_s;
  logic                    valid_q, valid_d;
  logic                    ready_q, ready_d;
  logic [OP_WIDTH-1:0]     main_op_q, main_op_d, skid_op_q, skid_op_d;
  logic [DATA_WIDTH-1:0]   main_a_q, main_a_d, skid_a_q, skid_a_d;
  logic [DATA_WIDTH-1:0]   main_b_q, main_b_d, skid_b_q, skid_b_d;
  logic [ADDR_WIDTH-1:0]   main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic                    in_s, out_s;
  logic [DATA_WIDTH-1:0]   new_a_s, new_b_s;

  assign in_s  = i_valid & ready_q;
  assign out_s = valid_q & i_ready;

  // Operand resolution for the op currently offered by decode.
  always_comb begin
    new_a_s = resolve_src(i_rs1Addr, i_rs1Data, i_fwdExValid, i_fwdExAddr, i_fwdExData,
                          i_fwdWbValid, i_fwdWbAddr, i_fwdWbData);
    if (i_useImm) begin
      new_b_s = i_imm;
    end else begin
      new_b_s = resolve_src(i_rs2Addr, i_rs2Data, i_fwdExValid, i_fwdExAddr, i_fwdExData,
                            i_fwdWbValid, i_fwdWbAddr, i_fwdWbData);
    end
  end

  // Skid-buffer next state and entry updates; flush overrides any transfer.
  always_comb begin
    state_fsm_s = state_q;
    main_op_d   = main_op_q;
    main_a_d    = main_a_q;
    main_b_d    = main_b_q;
    main_rd_d   = main_rd_q;
    skid_op_d   = skid_op_q;
    skid_a_d    = skid_a_q;
    skid_b_d    = skid_b_q;
    skid_rd_d   = skid_rd_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_s) begin
          state_fsm_s = ST_ONE;
          main_op_d   = i_op;
          main_a_d    = new_a_s;
          main_b_d    = new_b_s;
          main_rd_d   = i_rdAddr;
        end else begin
          state_fsm_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_s && !out_s) begin
          state_fsm_s = ST_FULL;
          skid_op_d   = i_op;
          skid_a_d    = new_a_s;
          skid_b_d    = new_b_s;
          skid_rd_d   = i_rdAddr;
        end else if (in_s && out_s) begin
          state_fsm_s = ST_ONE;
          main_op_d   = i_op;
          main_a_d    = new_a_s;
          main_b_d    = new_b_s;
          main_rd_d   = i_rdAddr;
        end else if (out_s) begin
          state_fsm_s = ST_EMPTY;
        end else begin
          state_fsm_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_s) begin
          state_fsm_s = ST_ONE;
          main_op_d   = skid_op_q;
          main_a_d    = skid_a_q;
          main_b_d    = skid_b_q;
          main_rd_d   = skid_rd_q;
        end else begin
          state_fsm_s = ST_FULL;
        end
      end
      default: begin
        state_fsm_s = ST_EMPTY;
      end
    endcase

    if (i_flush) begin
      state_d   = ST_EMPTY;
      skid_op_d = '0;
      skid_a_d  = '0;
      skid_b_d  = '0;
      skid_rd_d = '0;
    end else begin
      state_d = state_fsm_s;
    end

    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_FULL);
  end

  // State, handshake flags and both buffer entries.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_EMPTY;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      main_op_q <= '0;
      main_a_q  <= '0;
      main_b_q  <= '0;
      main_rd_q <= '0;
      skid_op_q <= '0;
      skid_a_q  <= '0;
      skid_b_q  <= '0;
      skid_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      main_op_q <= main_op_d;
      main_a_q  <= main_a_d;
      main_b_q  <= main_b_d;
      main_rd_q <= main_rd_d;
      skid_op_q <= skid_op_d;
      skid_a_q  <= skid_a_d;
      skid_b_q  <= skid_b_d;
      skid_rd_q <= skid_rd_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_ready  = ready_q;
  assign o_op     = main_op_q;
  assign o_dataA  = main_a_q;
  assign o_dataB  = main_b_q;
  assign o_rdAddr = main_rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: vector table, directed handshake corners and a
// random valid/ready run checked against a queue-based reference FIFO.
module tb_alu_operand_stage;

  logic        i_clock = 1'b0;
  logic        i_reset, i_flush, i_valid, i_ready, i_useImm;
  logic        i_fwdExValid, i_fwdWbValid;
  logic [3:0]  i_op;
  logic [4:0]  i_rs1Addr, i_rs2Addr, i_rdAddr, i_fwdExAddr, i_fwdWbAddr;
  logic [31:0] i_rs1Data, i_rs2Data, i_imm, i_fwdExData, i_fwdWbData;
  logic        o_ready, o_valid;
  logic [3:0]  o_op;
  logic [31:0] o_dataA, o_dataB;
  logic [4:0]  o_rdAddr;

  alu_operand_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_op(i_op), .i_rs1Addr(i_rs1Addr), .i_rs2Addr(i_rs2Addr),
    .i_rs1Data(i_rs1Data), .i_rs2Data(i_rs2Data), .i_imm(i_imm), .i_useImm(i_useImm),
    .i_rdAddr(i_rdAddr), .i_fwdExValid(i_fwdExValid), .i_fwdExAddr(i_fwdExAddr),
    .i_fwdExData(i_fwdExData), .i_fwdWbValid(i_fwdWbValid), .i_fwdWbAddr(i_fwdWbAddr),
    .i_fwdWbData(i_fwdWbData), .o_valid(o_valid), .i_ready(i_ready), .o_op(o_op),
    .o_dataA(o_dataA), .o_dataB(o_dataB), .o_rdAddr(o_rdAddr)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        useimm;
    logic        exv;
    logic [4:0]  exa;
    logic [31:0] exd;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
  } op_t;

  typedef struct {
    op_t         in;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_out    = 0;
  logic [72:0]  sb[$];
  vec_t         vecs[6];

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 5'd0) return rf;
    if (i_fwdExValid && i_fwdExAddr == addr) return i_fwdExData;
    if (i_fwdWbValid && i_fwdWbAddr == addr) return i_fwdWbData;
    return rf;
  endfunction

  function automatic logic [72:0] model();
    logic [31:0] a, b;
    a = pick(i_rs1Addr, i_rs1Data);
    b = i_useImm ? i_imm : pick(i_rs2Addr, i_rs2Data);
    return {i_op, a, b, i_rdAddr};
  endfunction

  // Reference FIFO: every negedge compares flags, pops on out, pushes on in.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      sb.delete();
    end else begin
      chk("o_valid_vs_model", {72'd0, o_valid}, {72'd0, sb.size() > 0});
      chk("o_ready_vs_model", {72'd0, o_ready}, {72'd0, sb.size() < 2});
      if (i_flush) begin
        sb.delete();
      end else begin
        if (o_valid && i_ready) begin
          n_out++;
          if (sb.size() == 0) chk("out_unexpected", {o_op, o_dataA, o_dataB, o_rdAddr}, 73'd0);
          else chk("out_data", {o_op, o_dataA, o_dataB, o_rdAddr}, sb.pop_front());
        end
        if (i_valid && o_ready) sb.push_back(model());
      end
    end
  end

  task automatic set_op(input op_t o);
    i_op = o.op; i_rs1Addr = o.rs1; i_rs2Addr = o.rs2; i_rdAddr = o.rd;
    i_rs1Data = o.d1; i_rs2Data = o.d2; i_imm = o.imm; i_useImm = o.useimm;
    i_fwdExValid = o.exv; i_fwdExAddr = o.exa; i_fwdExData = o.exd;
    i_fwdWbValid = o.wbv; i_fwdWbAddr = o.wba; i_fwdWbData = o.wbd;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.op = 4'($urandom); o.rs1 = 5'($urandom_range(0, 3)); o.rs2 = 5'($urandom_range(0, 3));
    o.rd = 5'($urandom); o.d1 = $urandom; o.d2 = $urandom; o.imm = $urandom;
    o.useimm = 1'($urandom); o.exv = 1'($urandom); o.exa = 5'($urandom_range(0, 3));
    o.exd = $urandom; o.wbv = 1'($urandom); o.wba = 5'($urandom_range(0, 3));
    o.wbd = $urandom;
    return o;
  endfunction

  // Offer an op until the stage takes it, bounded.
  task automatic send(input op_t o);
    logic acc;
    acc = 1'b0;
    set_op(o);
    i_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clock);
      acc = o_ready;
      @(posedge i_clock);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 73'd0, 73'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge i_clock);
      if (!o_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", {72'd0, done}, 73'd1);
    chk("drain_sb_empty", 73'(sb.size()), 73'd0);
    @(posedge i_clock);
    #1;
  endtask

  initial begin
    op_t oa, ob, oc;
    int  n0;

    for (int i = 0; i < 6; i++) vecs[i].in = '0;
    vecs[0].in.op = 4'd1; vecs[0].in.rs1 = 5'd5; vecs[0].in.d1 = 32'h11; vecs[0].in.rs2 = 5'd3;
    vecs[0].in.d2 = 32'h33; vecs[0].in.exv = 1'b1; vecs[0].in.exa = 5'd5; vecs[0].in.exd = 32'hAAAA;
    vecs[0].in.wbv = 1'b1; vecs[0].in.wba = 5'd5; vecs[0].in.wbd = 32'hBBBB; vecs[0].in.rd = 5'd1;
    vecs[0].exp_a = 32'hAAAA; vecs[0].exp_b = 32'h33;
    vecs[1].in.op = 4'd2; vecs[1].in.d1 = 32'h1234; vecs[1].in.d2 = 32'h55; vecs[1].in.exv = 1'b1;
    vecs[1].in.exd = 32'h1; vecs[1].in.wbv = 1'b1; vecs[1].in.wbd = 32'h9; vecs[1].in.rd = 5'd2;
    vecs[1].exp_a = 32'h1234; vecs[1].exp_b = 32'h55;
    vecs[2].in.op = 4'd3; vecs[2].in.useimm = 1'b1; vecs[2].in.imm = 32'hFFFFFFF0;
    vecs[2].in.rs2 = 5'd7; vecs[2].in.d2 = 32'h77; vecs[2].in.exv = 1'b1; vecs[2].in.exa = 5'd7;
    vecs[2].in.exd = 32'h7; vecs[2].in.rs1 = 5'd2; vecs[2].in.d1 = 32'h22; vecs[2].in.rd = 5'd3;
    vecs[2].exp_a = 32'h22; vecs[2].exp_b = 32'hFFFFFFF0;
    vecs[3].in.op = 4'd4; vecs[3].in.rs1 = 5'd9; vecs[3].in.d1 = 32'h99; vecs[3].in.exv = 1'b1;
    vecs[3].in.exa = 5'd8; vecs[3].in.exd = 32'hE8; vecs[3].in.wbv = 1'b1; vecs[3].in.wba = 5'd9;
    vecs[3].in.wbd = 32'hBBBB; vecs[3].in.rs2 = 5'd8; vecs[3].in.d2 = 32'h88; vecs[3].in.rd = 5'd4;
    vecs[3].exp_a = 32'hBBBB; vecs[3].exp_b = 32'hE8;
    vecs[4].in.op = 4'd5; vecs[4].in.rs1 = 5'd6; vecs[4].in.d1 = 32'h66; vecs[4].in.exa = 5'd6;
    vecs[4].in.exd = 32'hDEAD; vecs[4].in.wba = 5'd6; vecs[4].in.wbd = 32'hBEEF;
    vecs[4].in.rs2 = 5'd6; vecs[4].in.d2 = 32'h606; vecs[4].in.rd = 5'd5;
    vecs[4].exp_a = 32'h66; vecs[4].exp_b = 32'h606;
    vecs[5].in.op = 4'd6; vecs[5].in.rs1 = 5'd12; vecs[5].in.rs2 = 5'd12; vecs[5].in.d1 = 32'hC1;
    vecs[5].in.d2 = 32'hC2; vecs[5].in.wbv = 1'b1; vecs[5].in.wba = 5'd12;
    vecs[5].in.wbd = 32'h1200; vecs[5].in.rd = 5'd31;
    vecs[5].exp_a = 32'h1200; vecs[5].exp_b = 32'h1200;

    i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    set_op(op_t'(0));
    repeat (3) @(posedge i_clock);
    #1;
    chk("reset_o_valid", {72'd0, o_valid}, 73'd0);
    chk("reset_o_ready", {72'd0, o_ready}, 73'd1);
    chk("reset_outputs", {o_op, o_dataA, o_dataB, o_rdAddr}, 73'd0);
    i_reset = 1'b1;

    // Table vectors: one op into an empty stage, held with i_ready low.
    for (int i = 0; i < 6; i++) begin
      i_ready = 1'b0;
      set_op(vecs[i].in);
      i_valid = 1'b1;
      @(posedge i_clock);
      #1;
      i_valid = 1'b0;
      @(negedge i_clock);
      chk($sformatf("vec%0d_valid", i), {72'd0, o_valid}, 73'd1);
      chk($sformatf("vec%0d_dataA", i), 73'(o_dataA), 73'(vecs[i].exp_a));
      chk($sformatf("vec%0d_dataB", i), 73'(o_dataB), 73'(vecs[i].exp_b));
      chk($sformatf("vec%0d_op_rd", i), 73'({o_op, o_rdAddr}), 73'({vecs[i].in.op, vecs[i].in.rd}));
      @(posedge i_clock);
      #1;
      i_ready = 1'b1;
      @(posedge i_clock);
      #1;
      i_ready = 1'b0;
    end
    drain();

    // Backpressure: A held, B in skid, C refused until the ALU accepts.
    oa = rand_op(); oa.op = 4'hA;
    ob = rand_op(); ob.op = 4'hB;
    oc = rand_op(); oc.op = 4'hC;
    n0 = n_out;
    i_ready = 1'b0;
    send(oa);
    send(ob);
    set_op(oc);
    i_valid = 1'b1;
    repeat (3) begin
      @(negedge i_clock);
      chk("bp_ready_low", {72'd0, o_ready}, 73'd0);
      chk("bp_hold_A", 73'(o_op), 73'(4'hA));
      @(posedge i_clock);
      #1;
    end
    i_ready = 1'b1;
    send(oc);
    drain();
    chk("bp_out_count", 73'(n_out - n0), 73'd3);

    // Flush while FULL with a simultaneous incoming op.
    i_ready = 1'b0;
    send(rand_op());
    send(rand_op());
    set_op(rand_op());
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge i_clock);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clock);
    chk("flush_full_valid", {72'd0, o_valid}, 73'd0);
    chk("flush_full_ready", {72'd0, o_ready}, 73'd1);
    n0 = n_out;
    i_ready = 1'b1;
    repeat (3) @(posedge i_clock);
    #1;
    chk("flush_no_output", 73'(n_out - n0), 73'd0);

    // Flush in ONE with in and out both active.
    send(rand_op());
    set_op(rand_op());
    i_valid = 1'b1;
    i_flush = 1'b1;
    @(posedge i_clock);
    #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clock);
    chk("flush_one_valid", {72'd0, o_valid}, 73'd0);
    drain();

    // Asynchronous reset mid-stream.
    i_ready = 1'b0;
    oa = rand_op(); oa.rs1 = 5'd0; oa.d1 = 32'hCAFE0001;
    send(oa);
    send(rand_op());
    @(posedge i_clock);
    #3;
    i_reset = 1'b0;
    #1;
    chk("async_rst_valid", {72'd0, o_valid}, 73'd0);
    chk("async_rst_ready", {72'd0, o_ready}, 73'd1);
    chk("async_rst_dataA", 73'(o_dataA), 73'd0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;

    // Random valid/ready/flush traffic against the reference FIFO.
    for (int c = 0; c < 10000; c++) begin
      set_op(rand_op());
      i_valid = 1'($urandom);
      i_ready = 1'($urandom);
      i_flush = ($urandom_range(0, 63) == 0);
      @(posedge i_clock);
      #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
